// File: rtl/video_mem_arbiter.sv
// video_mem_arbiter
// Shares a single-port frame-buffer RAM between display scan-out and a
// buffered write client. The display owns every active-pixel cycle; queued
// writes drain only in blanking cycles. RAM controls and the returned pixel
// are registered.
module video_mem_arbiter #(
   parameter int H_ACTIVE   = 800,
   parameter int V_ACTIVE   = 600,
   parameter int ADDR_W     = 19,
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [10:0]                   H_count,
   input  logic [10:0]                   V_count,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic [ADDR_W-1:0]             wr_addr,
   input  logic [DATA_W-1:0]             wr_data,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic                          mem_we,
   output logic [DATA_W-1:0]             mem_wdata,
   input  logic [DATA_W-1:0]             mem_rdata,
   output logic [DATA_W-1:0]             Pix_color,
   output logic                          wr_err,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   localparam logic [10:0]       H_LIM       = 11'(H_ACTIVE);
   localparam logic [10:0]       V_LIM       = 11'(V_ACTIVE);
   localparam logic [ADDR_W:0]   FRAME_WORDS = (ADDR_W + 1)'(H_ACTIVE * V_ACTIVE);
   localparam logic [LVL_W-1:0]  LVL_FULL    = LVL_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0]  PTR_ONE     = PTR_W'(1);
   localparam logic [LVL_W-1:0]  LVL_ONE     = LVL_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);

   // A writer address is storable only if it falls inside the visible frame.
   function automatic logic addr_in_frame(input logic [ADDR_W-1:0] addr);
      return {1'b0, addr} < FRAME_WORDS;
   endfunction

   // Pixel returned to the adapter: fetched data for slot cycles, black otherwise.
   function automatic logic [DATA_W-1:0] pix_select(input logic vld, input logic [DATA_W-1:0] data);
      return vld ? data : '0;
   endfunction

   logic                disp_slot;
   logic                vblank;
   logic                accept;
   logic                push;
   logic                pop;
   logic                fifo_empty;
   logic [ADDR_W-1:0]   disp_addr;
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [ADDR_W-1:0]   fifo_addr [FIFO_DEPTH];
   logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
   logic [ADDR_W-1:0]   head_addr;
   logic [DATA_W-1:0]   head_data;
   logic                vld_p0;
   logic                vld_p1;

   // Cycle ownership: any active pixel belongs to the display.
   assign disp_slot  = (H_count < H_LIM) && (V_count < V_LIM);
   assign vblank     = (V_count >= V_LIM);

   // Writer handshake: held off during reset and whenever the queue is full.
   assign wr_ready   = rst && (fifo_level < LVL_FULL);
   assign accept     = wr_valid && wr_ready;
   assign push       = accept && addr_in_frame(wr_addr);

   // Drain only in cycles the display does not own.
   assign fifo_empty = (fifo_level == '0);
   assign pop        = !disp_slot && !fifo_empty;

   assign head_addr  = fifo_addr[rd_ptr];
   assign head_data  = fifo_data[rd_ptr];

   // Queue storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= wr_addr;
         fifo_data[wr_ptr] <= wr_data;
      end
   end

   // Queue pointers and occupancy; reset flushes everything still queued.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LVL_ONE;
            2'b01:   fifo_level <= fifo_level - LVL_ONE;
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // Sticky record of any accepted write that had to be dropped.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_err <= 1'b0;
      end else if (accept && !addr_in_frame(wr_addr)) begin
         wr_err <= 1'b1;
      end
   end

   // Raster read address; cleared through vertical blanking so each frame starts at 0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         disp_addr <= '0;
      end else if (vblank) begin
         disp_addr <= '0;
      end else if (disp_slot) begin
         disp_addr <= disp_addr + ADDR_ONE;
      end
   end

   // ---- stage p0: owner decision registered onto the RAM port ----
   // RAM port: display read, queued write, or idle with the address held.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (disp_slot) begin
         mem_we    <= 1'b0;
         mem_addr  <= disp_addr;
      end else if (pop) begin
         mem_we    <= 1'b1;
         mem_addr  <= head_addr;
         mem_wdata <= head_data;
      end else begin
         mem_we    <= 1'b0;
      end
   end

   // ---- stages p0/p1: slot flag follows the read through the registered RAM ----
   // Valid bits tracking which RAM outputs carry a display pixel.
   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p0 <= disp_slot;
         vld_p1 <= vld_p0;
      end
   end

   // ---- stage p2: pixel output, three clocks after the timing counters ----
   // Capture the fetched word, or black for cycles that were not display slots.
   always_ff @(posedge clk) begin
      if (!rst) begin
         Pix_color <= '0;
      end else begin
         Pix_color <= pix_select(vld_p1, mem_rdata);
      end
   end

endmodule

// File: tb/tb_video_mem_arbiter.sv
// tb_video_mem_arbiter
// Drives shortened video lines (800 active + 20 blanking) and a write client,
// models the RAM, and compares every output each cycle against a queue-based
// reference of the arbitration rules, plus directed literal expectations.
module tb_video_mem_arbiter;

   localparam int H_ACT = 800;
   localparam int V_ACT = 600;
   localparam int AW    = 19;
   localparam int DW    = 16;
   localparam int DEPTH = 4;
   localparam int H_TOT = 820;
   localparam int FRAME = H_ACT * V_ACT;

   logic          clk = 1'b0;
   logic          rst;
   logic [10:0]   H_count;
   logic [10:0]   V_count;
   logic          wr_valid;
   logic          wr_ready;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic [DW-1:0] Pix_color;
   logic          wr_err;
   logic [2:0]    fifo_level;

   int n_checks = 0;
   int n_errors = 0;

   video_mem_arbiter #(
      .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .H_count(H_count), .V_count(V_count),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .Pix_color(Pix_color), .wr_err(wr_err), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   // Registered single-port RAM
   logic [DW-1:0] ram [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t           mq[$];
   logic [DW-1:0] mram [int];
   int            m_disp  = 0;
   bit            m_we    = 1'b0;
   logic [AW-1:0] m_addr  = '0;
   logic [DW-1:0] m_wdata = '0;
   bit            m_err   = 1'b0;
   logic [DW-1:0] pa = '0, pb = '0, ppix = '0;

   function automatic logic [DW-1:0] ram_val(input int a);
      if (mram.exists(a)) return mram[a];
      return DW'(a);
   endfunction

   task automatic model_step();
      bit            slot;
      bit            ready;
      logic [DW-1:0] v;
      wr_t           h;
      wr_t           n;
      slot = (int'(H_count) < H_ACT) && (int'(V_count) < V_ACT);
      if (!rst) begin
         mq.delete();
         m_we = 1'b0; m_addr = '0; m_wdata = '0; m_err = 1'b0; m_disp = 0;
         pa = '0; pb = '0; ppix = '0;
      end else begin
         ready = (mq.size() < DEPTH);
         v = slot ? ram_val(m_disp) : '0;
         ppix = pb; pb = pa; pa = v;
         if (slot) begin
            m_we = 1'b0; m_addr = AW'(m_disp); m_disp = (m_disp + 1) % (1 << AW);
         end else if (mq.size() > 0) begin
            h = mq.pop_front();
            m_we = 1'b1; m_addr = h.a; m_wdata = h.d; mram[int'(h.a)] = h.d;
         end else begin
            m_we = 1'b0;
         end
         if (int'(V_count) >= V_ACT) m_disp = 0;
         if (wr_valid && ready) begin
            if (int'(wr_addr) < FRAME) begin
               n.a = wr_addr; n.d = wr_data; mq.push_back(n);
            end else begin
               m_err = 1'b1;
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, want, $time);
      end
   endtask

   // Per-cycle comparison against the model
   initial forever begin
      @(negedge clk);
      chk("wr_ready",   32'(wr_ready),   32'(rst && (mq.size() < DEPTH)));
      chk("mem_we",     32'(mem_we),     32'(m_we));
      chk("mem_addr",   32'(mem_addr),   32'(m_addr));
      chk("mem_wdata",  32'(mem_wdata),  32'(m_wdata));
      chk("Pix_color",  32'(Pix_color),  32'(ppix));
      chk("wr_err",     32'(wr_err),     32'(m_err));
      chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
   end

   // ---------------- stimulus ----------------
   task automatic step(input bit r, input int h, input int v, input bit vld, input int a, input int d);
      @(posedge clk);
      #1;
      rst = r; H_count = 11'(h); V_count = 11'(v);
      wr_valid = vld; wr_addr = AW'(a); wr_data = DW'(d);
      @(negedge clk);
   endtask

   function automatic int pick_addr();
      int r;
      r = int'($urandom_range(15));
      if (r == 0) return FRAME + int'($urandom_range(1000));
      if (r == 1) return (1 << AW) - 1;
      return int'($urandom_range(8799, 800));
   endfunction

   task automatic line(input int v, input int wr_pct, input bit pix_chk);
      bit vld;
      for (int h = 0; h < H_TOT; h++) begin
         vld = (int'($urandom_range(99)) < wr_pct);
         step(1'b1, h, v, vld, pick_addr(), int'($urandom_range(65535)));
         if (pix_chk && h == 3)   chk("pix_line_start", 32'(Pix_color), 32'(v * 800));
         if (pix_chk && h == 802) chk("pix_line_end",   32'(Pix_color), 32'(v * 800 + 799));
      end
   endtask

   task automatic vblank(input int n);
      for (int i = 0; i < n; i++) step(1'b1, i, V_ACT + (i % 20), 1'b0, 0, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; H_count = '0; V_count = '0;
      wr_valid = 1'b1; wr_addr = '0; wr_data = '0;
      for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(i);

      // Reset held with a pending writer
      for (int i = 0; i < 5; i++) begin
         step(1'b0, i, 0, 1'b1, 1234, 5);
         chk("rst_wr_ready", 32'(wr_ready),   32'd0);
         chk("rst_mem_we",   32'(mem_we),     32'd0);
         chk("rst_pix",      32'(Pix_color),  32'd0);
         chk("rst_level",    32'(fifo_level), 32'd0);
      end
      vblank(4);

      // Plain scan-out of lines 0 and 1
      line(0, 0, 1'b1);
      line(1, 0, 1'b1);

      // Four pushes mid-line, drained in hblank
      for (int h = 0; h < H_TOT; h++) begin
         step(1'b1, h, 5, (h >= 10 && h <= 13), 1000 + h - 10, 16'hA000 + h - 10);
         if (h == 13) chk("t3_ready_4th", 32'(wr_ready), 32'd1);
         if (h == 14) begin
            chk("t3_ready_full", 32'(wr_ready),   32'd0);
            chk("t3_level_full", 32'(fifo_level), 32'd4);
         end
         if (h >= 10 && h <= 800) chk("t3_no_write_active", 32'(mem_we), 32'd0);
         if (h >= 801 && h <= 804) begin
            chk("t3_we",    32'(mem_we),    32'd1);
            chk("t3_addr",  32'(mem_addr),  32'(1000 + h - 801));
            chk("t3_wdata", 32'(mem_wdata), 32'(16'hA000 + h - 801));
         end
         if (h == 805) begin
            chk("t3_level_drained", 32'(fifo_level), 32'd0);
            chk("t3_we_done",       32'(mem_we),     32'd0);
         end
      end

      // Push and pop together at level 2
      for (int h = 0; h < H_TOT; h++) begin
         step(1'b1, h, 6, (h == 20 || h == 21 || h == 800),
              (h == 800) ? 1102 : 1100 + h - 20, (h == 800) ? 16'hB002 : 16'hB000 + h - 20);
         if (h == 800) chk("t4_level_before", 32'(fifo_level), 32'd2);
         if (h == 801) begin
            chk("t4_level_same", 32'(fifo_level), 32'd2);
            chk("t4_addr0",      32'(mem_addr),   32'd1100);
            chk("t4_we0",        32'(mem_we),     32'd1);
         end
         if (h == 802) chk("t4_addr1", 32'(mem_addr), 32'd1101);
         if (h == 803) begin
            chk("t4_addr2",  32'(mem_addr),  32'd1102);
            chk("t4_wdata2", 32'(mem_wdata), 32'hB002);
         end
         if (h == 804) chk("t4_idle", 32'(mem_we), 32'd0);
      end

      // Out-of-range write dropped, later write still lands
      for (int h = 0; h < H_TOT; h++) begin
         step(1'b1, h, 7, (h == 30 || h == 40), (h == 30) ? FRAME : 1200, (h == 30) ? 16'hDEAD : 16'hC000);
         if (h == 30) chk("t5_handshake", 32'(wr_ready), 32'd1);
         if (h == 31) begin
            chk("t5_err",   32'(wr_err),     32'd1);
            chk("t5_level", 32'(fifo_level), 32'd0);
         end
         if (h == 801) begin
            chk("t5_we",    32'(mem_we),    32'd1);
            chk("t5_addr",  32'(mem_addr),  32'd1200);
            chk("t5_wdata", 32'(mem_wdata), 32'hC000);
         end
         if (h == 802) chk("t5_err_sticky", 32'(wr_err), 32'd1);
      end

      // Random writer traffic
      for (int v = 8; v < 16; v++) line(v, 30, 1'b0);
      vblank(30);

      // Reset mid-line with three queued writes
      for (int h = 0; h < H_TOT; h++) begin
         step((h != 400), h, 0, (h >= 397 && h <= 399), 2000 + h - 397, 16'hE000 + h - 397);
         if (h == 400) begin
            chk("t6_level_queued", 32'(fifo_level), 32'd3);
            chk("t6_ready_in_rst", 32'(wr_ready),   32'd0);
         end
         if (h == 401) begin
            chk("t6_level_flushed", 32'(fifo_level), 32'd0);
            chk("t6_err_cleared",   32'(wr_err),     32'd0);
            chk("t6_pix_cleared",   32'(Pix_color),  32'd0);
         end
         if (h >= 800) chk("t6_no_write", 32'(mem_we), 32'd0);
      end
      vblank(5);
      line(0, 0, 1'b1);
      line(1, 20, 1'b0);
      line(2, 20, 1'b0);
      vblank(10);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
